// File: rtl/host_arb_pkg.sv
// Shared types and constants for the host-memory write arbiter: FSM states,
// burst limit and the default MSI-X message.
package host_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_MSIX = 2'd2
  } arb_state_t;

  localparam int          MAX_BURST     = 16;
  localparam logic [63:0] MSIX_ADDR_DEF = 64'h0000_0000_0000_0001;
  localparam logic [31:0] MSIX_DATA_DEF = 32'h1234_5678;

  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > 5'(MAX_BURST)) ? 5'(MAX_BURST) : len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first set request found searching upward from i_ptr,
// wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_found
);

  logic [PTR_W-1:0] w_idx;

  // Rotating priority search starting at the pointer.
  always_comb begin
    o_gnt   = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = PTR_W'((int'(i_ptr) + i) % NUM_REQ);
      if (!o_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_found      = 1'b1;
      end else begin
        o_found = o_found;
      end
    end
  end

endmodule

// File: rtl/host_mem_wr_arb.sv
// Arbitrates DW write bursts from NUM_REQ requesters onto one host-memory write
// port, optionally following a burst with an MSI-X message write.
module host_mem_wr_arb
  import host_arb_pkg::*;
#(
  parameter int          NUM_REQ   = 4,
  parameter logic [63:0] MSIX_ADDR = MSIX_ADDR_DEF,
  parameter logic [31:0] MSIX_DATA = MSIX_DATA_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*64-1:0] req_addr,
  input  logic [NUM_REQ*5-1:0]  req_len,
  input  logic [NUM_REQ-1:0]    req_intr,
  output logic [NUM_REQ-1:0]    req_grant,
  input  logic [NUM_REQ-1:0]    req_data_valid,
  input  logic [NUM_REQ*32-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_data_ready,
  output logic                  mem_wr_valid,
  output logic [63:0]           mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  input  logic                  mem_wr_ready,
  output logic                  msix_sent,
  output logic                  busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, r_owner, w_gnt_idx, w_ptr_nxt;
  logic [63:0]        r_addr, w_sel_addr;
  logic [4:0]         r_rem, w_sel_len;
  logic               r_intr, w_sel_intr;
  logic [NUM_REQ-1:0] w_arb_gnt;
  logic               w_arb_found, w_own_dv, w_take, w_beat;
  logic [31:0]        w_own_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_arb_gnt),
    .o_found (w_arb_found)
  );

  // AND-OR select of the granted request's fields and the owner's data lane.
  always_comb begin
    w_gnt_idx  = '0;
    w_sel_addr = '0;
    w_sel_len  = '0;
    w_sel_intr = 1'b0;
    w_own_data = '0;
    w_own_dv   = req_data_valid[r_owner];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_gnt_idx  = PTR_W'(i);
        w_sel_addr = req_addr[i*64 +: 64];
        w_sel_len  = clamp_len(req_len[i*5 +: 5]);
        w_sel_intr = req_intr[i];
      end else begin
        w_gnt_idx = w_gnt_idx;
      end
      if (r_owner == PTR_W'(i)) begin
        w_own_data = req_data[i*32 +: 32];
      end else begin
        w_own_data = w_own_data;
      end
    end
    w_ptr_nxt = (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
  end

  // Next state and output muxing; reset forces every output low at once.
  always_comb begin
    w_state_nxt    = r_state;
    req_grant      = '0;
    req_data_ready = '0;
    mem_wr_valid   = 1'b0;
    mem_wr_addr    = '0;
    mem_wr_data    = '0;
    msix_sent      = 1'b0;
    busy           = 1'b0;
    w_take         = 1'b0;
    w_beat         = 1'b0;
    if (rst) begin
      w_state_nxt = ST_IDLE;
    end else begin
      busy = (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_arb_found) begin
            w_take    = 1'b1;
            req_grant = w_arb_gnt;
            if (w_sel_len != 5'd0)  w_state_nxt = ST_DATA;
            else if (w_sel_intr)    w_state_nxt = ST_MSIX;
            else                    w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DATA: begin
          mem_wr_valid            = w_own_dv;
          mem_wr_addr             = r_addr;
          mem_wr_data             = w_own_data;
          req_data_ready[r_owner] = mem_wr_ready;
          w_beat                  = w_own_dv & mem_wr_ready;
          if (w_beat && (r_rem == 5'd1)) w_state_nxt = r_intr ? ST_MSIX : ST_IDLE;
          else                           w_state_nxt = ST_DATA;
        end
        ST_MSIX: begin
          mem_wr_valid = 1'b1;
          mem_wr_addr  = MSIX_ADDR;
          mem_wr_data  = MSIX_DATA;
          msix_sent    = mem_wr_ready;
          w_state_nxt  = mem_wr_ready ? ST_IDLE : ST_MSIX;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, round-robin pointer and burst context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_addr   <= '0;
      r_rem    <= '0;
      r_intr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_take) begin
        r_rr_ptr <= w_ptr_nxt;
        r_owner  <= w_gnt_idx;
        r_addr   <= w_sel_addr;
        r_rem    <= w_sel_len;
        r_intr   <= w_sel_intr;
      end else if (w_beat) begin
        r_addr <= r_addr + 64'd4;
        r_rem  <= r_rem - 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_host_mem_wr_arb.sv
// Scoreboard bench for host_mem_wr_arb: directed bursts push expected grants
// and writes; a negedge monitor pops and compares whatever the DUT presents.
module tb_host_mem_wr_arb;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_intr, req_grant, req_data_valid, req_data_ready;
  logic [N*64-1:0]   req_addr;
  logic [N*5-1:0]    req_len;
  logic [N*32-1:0]   req_data;
  logic              mem_wr_valid, mem_wr_ready, msix_sent, busy;
  logic [63:0]       mem_wr_addr;
  logic [31:0]       mem_wr_data;

  host_mem_wr_arb #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_intr(req_intr),
    .req_grant(req_grant), .req_data_valid(req_data_valid), .req_data(req_data),
    .req_data_ready(req_data_ready), .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ready(mem_wr_ready), .msix_sent(msix_sent), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
    logic        msix;
  } wr_t;

  wr_t  exp_wr_q[$];
  int   exp_gnt_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int   issued   [N] = '{default: 0};
  int   granted  [N] = '{default: 0};
  int   beat_cnt [N] = '{default: 0};
  int   exp_cnt  [N] = '{default: 0};
  logic [N-1:0] xfer_s = '0;
  logic [N-1:0] gnt_s  = '0;
  logic [N-1:0] chk_gnt = '0;
  bit   tog_en = 1'b0;
  bit   gap_en = 1'b0;
  int   cyc = 0;
  int   chk_mode = 0;

  function automatic logic [31:0] dval(input int r, input int k);
    return 32'hD000_0000 | (32'(r) << 16) | 32'(k);
  endfunction

  // Requester/memory model: holds requests until granted, advances data on transfer.
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    for (int r = 0; r < N; r++) begin
      if (xfer_s[r]) beat_cnt[r] = beat_cnt[r] + 1;
      if (gnt_s[r])  granted[r]  = granted[r] + 1;
      req_valid[r]          = (issued[r] != granted[r]);
      req_data_valid[r]     = !(gap_en && (cyc % 3 == 1));
      req_data[r*32 +: 32]  = dval(r, beat_cnt[r]);
    end
    mem_wr_ready = tog_en ? cyc[0] : 1'b1;
  end

  wr_t          m_w;
  int           m_e;
  logic [N-1:0] m_oh;
  logic         prev_stall = 1'b0;
  logic [63:0]  prev_addr = '0;
  logic [31:0]  prev_data = '0;

  // Monitor: scoreboard pops plus on-demand checks requested by the stimulus.
  always @(negedge clk) begin
    xfer_s = req_data_valid & req_data_ready;
    gnt_s  = req_grant;
    if (!rst) begin
      if (req_grant != '0) begin
        n_tests++;
        if (exp_gnt_q.size() == 0) begin
          n_fail++; $display("FAIL grant_unexpected: got %b required none", req_grant);
        end else begin
          m_e = exp_gnt_q.pop_front();
          m_oh = '0; m_oh[m_e] = 1'b1;
          if (req_grant != m_oh) begin
            n_fail++; $display("FAIL grant_order: got %b required %b", req_grant, m_oh);
          end
        end
      end
      if (mem_wr_valid && mem_wr_ready) begin
        n_tests++;
        if (exp_wr_q.size() == 0) begin
          n_fail++; $display("FAIL write_unexpected: got addr %h data %h", mem_wr_addr, mem_wr_data);
        end else begin
          m_w = exp_wr_q.pop_front();
          if (mem_wr_addr != m_w.addr || mem_wr_data != m_w.data || msix_sent != m_w.msix) begin
            n_fail++;
            $display("FAIL write: got addr %h data %h msix %b required addr %h data %h msix %b",
                     mem_wr_addr, mem_wr_data, msix_sent, m_w.addr, m_w.data, m_w.msix);
          end
        end
      end else if (msix_sent) begin
        n_tests++; n_fail++; $display("FAIL msix_spurious: got 1 required 0");
      end
      if (prev_stall && mem_wr_valid) begin
        n_tests++;
        if (mem_wr_addr != prev_addr || mem_wr_data != prev_data) begin
          n_fail++;
          $display("FAIL stall_stable: got %h/%h required %h/%h",
                   mem_wr_addr, mem_wr_data, prev_addr, prev_data);
        end
      end
      prev_stall = mem_wr_valid && !mem_wr_ready;
      prev_addr  = mem_wr_addr;
      prev_data  = mem_wr_data;
    end else begin
      prev_stall = 1'b0;
    end
    case (chk_mode)
      1: begin
        n_tests++;
        if (req_grant != '0 || req_data_ready != '0 || mem_wr_valid || mem_wr_addr != '0 ||
            mem_wr_data != '0 || msix_sent || busy) begin
          n_fail++;
          $display("FAIL reset_outputs: got gnt %b rdy %b v %b a %h d %h msix %b busy %b required all 0",
                   req_grant, req_data_ready, mem_wr_valid, mem_wr_addr, mem_wr_data, msix_sent, busy);
        end
      end
      2: begin
        n_tests++;
        if (busy || mem_wr_valid) begin
          n_fail++; $display("FAIL idle: got busy %b valid %b required 0 0", busy, mem_wr_valid);
        end
      end
      3: begin
        n_tests++;
        if (req_grant != chk_gnt) begin
          n_fail++; $display("FAIL grant_after_reset: got %b required %b", req_grant, chk_gnt);
        end
      end
      4: begin
        n_tests++; n_fail++; $display("FAIL timeout: expected traffic not seen within budget");
      end
      default: ;
    endcase
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_now(input int m);
    chk_mode = m;
    step(1);
    chk_mode = 0;
  endtask

  task automatic issue(input int r, input logic [63:0] a, input logic [4:0] l, input logic intr);
    req_addr[r*64 +: 64] = a;
    req_len[r*5 +: 5]    = l;
    req_intr[r]          = intr;
    issued[r]            = issued[r] + 1;
  endtask

  task automatic push_burst(input int r, input logic [63:0] a, input int n);
    exp_gnt_q.push_back(r);
    for (int k = 0; k < n; k++) begin
      exp_wr_q.push_back('{addr: a + 64'(4 * k), data: dval(r, exp_cnt[r]), msix: 1'b0});
      exp_cnt[r] = exp_cnt[r] + 1;
    end
  endtask

  task automatic push_msix();
    exp_wr_q.push_back('{addr: 64'h1, data: 32'h1234_5678, msix: 1'b1});
  endtask

  task automatic wait_drain(input int limit);
    int t;
    t = 0;
    while ((exp_wr_q.size() != 0 || exp_gnt_q.size() != 0) && t < limit) begin
      step(1);
      t++;
    end
    if (exp_wr_q.size() != 0 || exp_gnt_q.size() != 0) begin
      exp_wr_q.delete();
      exp_gnt_q.delete();
      check_now(4);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; req_addr = '0; req_len = '0; req_intr = '0;
    step(2);
    check_now(1);
    rst = 1'b0;

    // Plain 4-beat burst from requester 0.
    push_burst(0, 64'h1000, 4);
    issue(0, 64'h1000, 5'd4, 1'b0);
    wait_drain(60); check_now(2);

    // Two beats then MSI-X.
    push_burst(1, 64'h2000, 2); push_msix();
    issue(1, 64'h2000, 5'd2, 1'b1);
    wait_drain(60); check_now(2);

    // Zero-length: MSI-X only, then grant only.
    push_burst(2, 64'h7000, 0); push_msix();
    issue(2, 64'h7000, 5'd0, 1'b1);
    wait_drain(60);
    push_burst(3, 64'h7100, 0);
    issue(3, 64'h7100, 5'd0, 1'b0);
    wait_drain(60); check_now(2);

    // All four held, requester 0 twice: rotation 0,1,2,3,0.
    push_burst(0, 64'h6000, 1); push_burst(1, 64'h6100, 1);
    push_burst(2, 64'h6200, 1); push_burst(3, 64'h6300, 1);
    push_burst(0, 64'h6000, 1);
    issue(0, 64'h6000, 5'd1, 1'b0); issue(1, 64'h6100, 5'd1, 1'b0);
    issue(2, 64'h6200, 5'd1, 1'b0); issue(3, 64'h6300, 5'd1, 1'b0);
    issue(0, 64'h6000, 5'd1, 1'b0);
    wait_drain(100); check_now(2);

    // Backpressure and data gaps.
    tog_en = 1'b1; gap_en = 1'b1;
    push_burst(1, 64'h3000, 6);
    issue(1, 64'h3000, 5'd6, 1'b0);
    wait_drain(200);
    tog_en = 1'b0; gap_en = 1'b0;
    check_now(2);

    // Reset after two beats of a 4-beat interrupt burst.
    push_burst(2, 64'h4000, 4);
    issue(2, 64'h4000, 5'd4, 1'b1);
    t = 0;
    while (exp_wr_q.size() > 2 && t < 60) begin step(1); t++; end
    rst = 1'b1;
    if (exp_wr_q.size() != 2) check_now(4);
    exp_wr_q.delete(); exp_gnt_q.delete();
    exp_cnt[2] = exp_cnt[2] - 2;
    push_burst(3, 64'hFFFF_FFFF_FFFF_FFFC, 2);
    issue(3, 64'hFFFF_FFFF_FFFF_FFFC, 5'd2, 1'b0);
    check_now(1); check_now(1);
    rst = 1'b0;
    chk_gnt = 4'b1000;
    check_now(3);
    wait_drain(60); check_now(2);

    // Length above 16 clamps to 16.
    push_burst(0, 64'h5000, 16);
    issue(0, 64'h5000, 5'd31, 1'b0);
    wait_drain(100); check_now(2);

    step(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
